// File: rtl/sensor_alarm_ctrl.sv
// Multi-channel sensor alarm controller: debounces sensor inputs and drives a
// one-hot buzzer for the highest-priority qualified channel, then cools down.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for any sensor bit
// S_QUALIFY | counting consecutive samples of the same candidate channel
// S_ALARM   | buzzer on; sensors ignored until timeout or ack
// S_COOL    | post-alarm window; sensors ignored for COOLDOWN cycles
module sensor_alarm_ctrl #(
    parameter int NUM_CH    = 3,
    parameter int DEBOUNCE  = 7,
    parameter int ALARM_LEN = 31,
    parameter int CNT_W     = 5,
    parameter int COOLDOWN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] sensor,
    input  logic              latch_mode,
    input  logic              ack,
    output logic [NUM_CH-1:0] buzzer,
    output logic              alarm_active,
    output logic [2:0]        alarm_ch,
    output logic [7:0]        event_count
);

    // Debounce counter is widened when DEBOUNCE does not fit in CNT_W bits.
    localparam int D_W = ($clog2(DEBOUNCE + 1) > CNT_W) ? $clog2(DEBOUNCE + 1) : CNT_W;

    localparam logic [D_W-1:0]   DEB_TC  = D_W'(DEBOUNCE);
    localparam logic [D_W-1:0]   D_ONE   = D_W'(1);
    localparam logic [CNT_W-1:0] ALEN_TC = CNT_W'(ALARM_LEN);
    localparam logic [CNT_W-1:0] COOL_TC = CNT_W'(COOLDOWN);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_QUALIFY,
        S_ALARM,
        S_COOL
    } state_t;

    state_t           state;
    logic [2:0]       track_ch;
    logic [2:0]       cand;
    logic             any;
    logic [D_W-1:0]   dcnt;
    logic [CNT_W-1:0] acnt;
    logic [CNT_W-1:0] ccnt;
    logic             go_alarm;
    logic             alarm_done;

    // Lowest-index asserted bit wins.
    always_comb begin
        cand = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (sensor[i]) begin
                cand = 3'(i);
            end
        end
    end

    assign any = |sensor;

    function automatic logic [NUM_CH-1:0] onehot(input logic [2:0] ch);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (3'(i) == ch) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    always_comb begin
        go_alarm = 1'b0;
        if (state == S_IDLE) begin
            go_alarm = any && (DEBOUNCE == 1);
        end else if (state == S_QUALIFY) begin
            go_alarm = any && (cand == track_ch) && ((dcnt + D_ONE) == DEB_TC);
        end
    end

    assign alarm_done = ack || (!latch_mode && (acnt >= ALEN_TC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            track_ch     <= '0;
            dcnt         <= '0;
            acnt         <= '0;
            ccnt         <= '0;
            buzzer       <= '0;
            alarm_active <= 1'b0;
            alarm_ch     <= '0;
            event_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any) begin
                        track_ch <= cand;
                        dcnt     <= D_ONE;
                        state    <= S_QUALIFY;
                    end else begin
                        dcnt <= '0;
                    end
                end
                S_QUALIFY: begin
                    if (!any) begin
                        dcnt  <= '0;
                        state <= S_IDLE;
                    end else if (cand != track_ch) begin
                        track_ch <= cand;
                        dcnt     <= D_ONE;
                    end else begin
                        dcnt <= dcnt + D_ONE;
                    end
                end
                S_ALARM: begin
                    if (alarm_done) begin
                        buzzer       <= '0;
                        alarm_active <= 1'b0;
                        ccnt         <= '0;
                        dcnt         <= '0;
                        state        <= (COOLDOWN == 0) ? S_IDLE : S_COOL;
                    end else if (acnt < ALEN_TC) begin
                        acnt <= acnt + C_ONE;
                    end
                end
                S_COOL: begin
                    ccnt <= ccnt + C_ONE;
                    if ((ccnt + C_ONE) == COOL_TC) begin
                        dcnt  <= '0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Alarm entry overrides the IDLE/QUALIFY next-state chosen above.
            if (go_alarm) begin
                buzzer       <= onehot(cand);
                alarm_active <= 1'b1;
                alarm_ch     <= cand;
                acnt         <= C_ONE;
                state        <= S_ALARM;
                if (event_count != 8'hFF) begin
                    event_count <= event_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// Self-checking bench for sensor_alarm_ctrl: directed vector table, corner
// sequences, and randomized traffic against a streak/timer reference model.
module tb_sensor_alarm_ctrl;

    localparam int DEB  = 7;
    localparam int ALEN = 31;
    localparam int COOL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sensor;
    logic       latch_mode;
    logic       ack;
    logic [2:0] buzzer;
    logic       alarm_active;
    logic [2:0] alarm_ch;
    logic [7:0] event_count;

    logic [7:0] sensor8;
    logic       latch8;
    logic       ack8;
    logic [7:0] buzzer8;
    logic       alarm_active8;
    logic [2:0] alarm_ch8;
    logic [7:0] event_count8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sensor_alarm_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .sensor       (sensor),
        .latch_mode   (latch_mode),
        .ack          (ack),
        .buzzer       (buzzer),
        .alarm_active (alarm_active),
        .alarm_ch     (alarm_ch),
        .event_count  (event_count)
    );

    sensor_alarm_ctrl #(
        .NUM_CH    (8),
        .DEBOUNCE  (1),
        .ALARM_LEN (1),
        .CNT_W     (5),
        .COOLDOWN  (0)
    ) dut8 (
        .clk          (clk),
        .rst          (rst),
        .sensor       (sensor8),
        .latch_mode   (latch8),
        .ack          (ack8),
        .buzzer       (buzzer8),
        .alarm_active (alarm_active8),
        .alarm_ch     (alarm_ch8),
        .event_count  (event_count8)
    );

    // Reference model: a run-length of identical candidates, an alarm age and
    // a cooldown countdown, all derived from the behavioural rules.
    int m_streak, m_sch, m_age, m_cool, m_count, m_ch;
    bit m_alarm;

    task automatic model_reset();
        m_streak = 0; m_sch = 0; m_age = 0; m_cool = 0;
        m_count = 0; m_ch = 0; m_alarm = 0;
    endtask

    task automatic model_step(input logic [2:0] s, input bit lm, input bit a);
        int c;
        c = -1;
        for (int i = 0; i < 3; i++) if (s[i] && c < 0) c = i;
        if (m_alarm) begin
            if (a || (!lm && m_age >= ALEN)) begin
                m_alarm  = 0;
                m_cool   = COOL;
                m_streak = 0;
            end else begin
                m_age++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (c < 0) begin
            m_streak = 0;
        end else begin
            if (m_streak > 0 && c == m_sch) m_streak++;
            else begin m_streak = 1; m_sch = c; end
            if (m_streak == DEB) begin
                m_alarm  = 1;
                m_age    = 1;
                m_ch     = c;
                m_streak = 0;
                if (m_count < 255) m_count++;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(sensor, latch_mode, ack);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic run_until_alarm(output int n, input int limit);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!alarm_active && n < limit);
    endtask

    typedef struct {
        logic [2:0] pat;
        logic [2:0] exp_buz;
        int         exp_ch;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, d, bad;
        logic [2:0] exp_buz;

        vecs[0] = '{3'b001, 3'b001, 0};
        vecs[1] = '{3'b011, 3'b001, 0};
        vecs[2] = '{3'b010, 3'b010, 1};
        vecs[3] = '{3'b110, 3'b010, 1};
        vecs[4] = '{3'b100, 3'b100, 2};
        vecs[5] = '{3'b111, 3'b001, 0};

        rst = 1'b1; sensor = '0; latch_mode = 1'b0; ack = 1'b0;
        sensor8 = '0; latch8 = 1'b0; ack8 = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("reset_buzzer", buzzer, 0);
        chk("reset_active", alarm_active, 0);
        chk("reset_ch", alarm_ch, 0);
        chk("reset_count", event_count, 0);
        do_reset();

        // Timed-mode vectors: latency, winner, on-time.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            sensor = vecs[v].pat;
            run_until_alarm(n, 50);
            chk($sformatf("vec%0d_latency", v), n, DEB);
            chk($sformatf("vec%0d_buzzer", v), buzzer, vecs[v].exp_buz);
            chk($sformatf("vec%0d_ch", v), alarm_ch, vecs[v].exp_ch);
            chk($sformatf("vec%0d_count", v), event_count, 1);
            d = 1;
            for (int k = 0; k < 100; k++) begin
                cycle();
                if (!alarm_active) break;
                d++;
            end
            chk($sformatf("vec%0d_ontime", v), d, ALEN);
            chk($sformatf("vec%0d_buz_off", v), buzzer, 0);
            chk($sformatf("vec%0d_ch_hold", v), alarm_ch, vecs[v].exp_ch);
        end

        // One-cycle dropout restarts the debounce.
        do_reset();
        sensor = 3'b001;
        bad = 0;
        for (int k = 0; k < 6; k++) begin cycle(); if (alarm_active) bad++; end
        chk("glitch_no_early", bad, 0);
        sensor = 3'b000;
        cycle();
        sensor = 3'b001;
        run_until_alarm(n, 50);
        chk("glitch_latency", n, DEB);
        chk("glitch_buzzer", buzzer, 1);

        // Candidate change restarts the debounce.
        do_reset();
        sensor = 3'b010;
        bad = 0;
        for (int k = 0; k < 4; k++) begin cycle(); if (alarm_active) bad++; end
        sensor = 3'b100;
        run_until_alarm(n, 50);
        chk("restart_no_early", bad, 0);
        chk("restart_latency", n, DEB);
        chk("restart_buzzer", buzzer, 4);
        chk("restart_ch", alarm_ch, 2);

        // Latched mode, ack, cooldown, re-qualification.
        do_reset();
        latch_mode = 1'b1;
        sensor = 3'b001;
        run_until_alarm(n, 50);
        chk("latch_latency", n, DEB);
        bad = 0;
        for (int k = 0; k < 42; k++) begin cycle(); if (!alarm_active) bad++; end
        chk("latch_held", bad, 0);
        chk("latch_buzzer", buzzer, 1);
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        chk("ack_buzzer", buzzer, 0);
        chk("ack_active", alarm_active, 0);
        chk("ack_ch_hold", alarm_ch, 0);
        bad = 0;
        for (int k = 0; k < COOL + DEB - 1; k++) begin cycle(); if (alarm_active) bad++; end
        chk("cool_ignored", bad, 0);
        cycle();
        chk("realarm_active", alarm_active, 1);
        chk("realarm_count", event_count, 2);
        latch_mode = 1'b0;

        // Asynchronous reset between edges during an alarm.
        do_reset();
        sensor = 3'b001;
        run_until_alarm(n, 50);
        cycle(); cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_buzzer", buzzer, 0);
        chk("async_rst_active", alarm_active, 0);
        chk("async_rst_count", event_count, 0);
        chk("async_rst_ch", alarm_ch, 0);
        #1;
        rst = 1'b0;
        model_reset();
        run_until_alarm(n, 50);
        chk("post_rst_latency", n, DEB);
        chk("post_rst_count", event_count, 1);

        // 8-channel fast re-trigger and event counter saturation.
        do_reset();
        sensor = '0;
        sensor8 = 8'h80;
        cycle();
        chk("fast_first_buzzer", buzzer8, 8'h80);
        chk("fast_first_ch", alarm_ch8, 7);
        bad = 0;
        for (int e = 2; e <= 600; e++) begin
            cycle();
            if (alarm_active8 != (e % 2 == 1)) bad++;
            if (e == 21) chk("fast_count_mid", event_count8, 11);
        end
        chk("fast_pattern", bad, 0);
        chk("fast_saturated", event_count8, 255);
        chk("fast_ch", alarm_ch8, 7);
        sensor8 = '0;

        // Randomized traffic against the reference model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(7) == 0) sensor = 3'($urandom_range(7));
            if ($urandom_range(63) == 0) latch_mode = ~latch_mode;
            ack = ($urandom_range(29) == 0);
            cycle();
            exp_buz = m_alarm ? (3'b001 << m_ch) : 3'b000;
            chk("rand_outputs", {buzzer, alarm_active, alarm_ch, event_count},
                {exp_buz, m_alarm, 3'(m_ch), 8'(m_count)});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
